score_display: RTL and testbench

Sequential multi-digit successor to the single-digit HEX decoder. Captures a BIN_W-bit unsigned binary value and converts it to DIGITS BCD digits with an iterative shift-add-3 (double-dabble) engine. Drives DIGITS active-low seven-segment HEX displays. Sits between the game score counter and the board HEX outputs; the display holds the last value until a new conversion completes.

---
 rtl/score_display_pkg.sv | 26 ++
 rtl/seg7_digit.sv | 25 ++
 rtl/score_display.sv | 112 +++++++++++
 tb/tb_score_display.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared types and seven-segment patterns for the score_display block.
`timescale 1ns/1ps
package score_display_pkg;

  localparam int SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  // Uninverted patterns, bit order g..a; the display driver inverts them.
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111
  };
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;

  // Double-dabble correction so the following shift carries into the next decade.
  function automatic logic [3:0] add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// One active-low seven-segment digit decoder with blank and dash overrides.
`timescale 1ns/1ps
module seg7_digit
  import score_display_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             blank,
  input  logic             dash,
  output logic [SEG_W-1:0] seg
);

  logic [SEG_W-1:0] pattern;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pattern = SEG_BLANK;
    if (dash) begin
      pattern = SEG_DASH;
    end else if (!blank && (nibble <= 4'd9)) begin
      pattern = SEG_DIGIT[nibble];
    end
    seg = ~pattern;
  end

endmodule

// File: rtl/score_display.sv
// Binary-to-BCD (iterative double-dabble) converter driving DIGITS active-low HEX displays.
// Optional leading-zero blanking when SCORE_DISPLAY_LZB_EN is defined.
`timescale 1ns/1ps
module score_display
  import score_display_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load,
  input  logic [BIN_W-1:0]             value,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [DIGITS-1:0][SEG_W-1:0] hex
);

  localparam int          BCD_W      = DIGITS * 4;
  localparam int          CNT_W      = $clog2(BIN_W + 1);
  localparam int unsigned DISP_LIMIT = 10 ** DIGITS;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t                       state;
  logic [CNT_W-1:0]             iter;
  logic [BIN_W-1:0]             shift_q;
  logic [BCD_W-1:0]             bcd_q;
  logic [BCD_W-1:0]             bcd_adj;
  logic                         ovf_pending;
  logic [DIGITS-1:0]            blank;
  logic [DIGITS-1:0][SEG_W-1:0] seg_next;

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      bcd_adj[d*4 +: 4] = add3(bcd_q[d*4 +: 4]);
    end
  end

`ifdef SCORE_DISPLAY_LZB_EN
  logic lead_seen;

  // Walk down from the top digit; blank until the first nonzero digit. Digit 0 always shows.
  always_comb begin
    lead_seen = 1'b0;
    blank     = '0;
    for (int d = DIGITS - 1; d > 0; d--) begin
      if (bcd_q[d*4 +: 4] != 4'd0) begin
        lead_seen = 1'b1;
      end
      blank[d] = !lead_seen;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_digit u_digit (
      .nibble (bcd_q[g*4 +: 4]),
      .blank  (blank[g]),
      .dash   (ovf_pending),
      .seg    (seg_next[g])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      iter        <= '0;
      shift_q     <= '0;
      bcd_q       <= '0;
      ovf_pending <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      hex         <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift_q     <= value;
            bcd_q       <= '0;
            iter        <= '0;
            ovf_pending <= (32'(value) >= DISP_LIMIT);
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          // Bits leaving the BCD MSB are dropped; that only happens on overflow.
          {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
          iter             <= iter + CNT_W'(1);
          if (iter == LAST_ITER) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          hex      <= seg_next;
          overflow <= ovf_pending;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: stimulus pushes expected results, a monitor checks each done pulse.
`timescale 1ns/1ps
module tb_score_display;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  // Active-low segment patterns g..a.
  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S9   = 7'b0011000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BLK  = 7'b1111111;

`ifdef SCORE_DISPLAY_LZB_EN
  localparam logic [6:0] LZ = BLK;
`else
  localparam logic [6:0] LZ = S0;
`endif

  typedef struct {
    string       name;
    logic [27:0] hex;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic                  clk;
  logic                  reset_n;
  logic                  load;
  logic [BIN_W-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [DIGITS-1:0][6:0] hex;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic prev_done;

  score_display #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hex      (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_done) check("done_one_cycle", 64'(done), 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("done_without_request", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_hex"}, 64'(hex), 64'(e.hex));
          check({e.name, "_ovf"}, 64'(overflow), 64'(e.ovf));
          check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
          check({e.name, "_busy"}, 64'(busy), 64'd0);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Called at a negedge with the DUT idle; the following posedge accepts.
  task automatic issue(input logic [BIN_W-1:0] v, input logic [27:0] exp_hex,
                       input logic exp_ovf, input string name, input bit expect_done);
    exp_t e;
    load  = 1'b1;
    value = v;
    if (expect_done) begin
      e.name = name;
      e.hex  = exp_hex;
      e.ovf  = exp_ovf;
      e.cyc  = cyc + BIN_W + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    load  = 1'b0;
    value = '0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    prev_done = 1'b0;
    reset_n   = 1'b0;
    load      = 1'b0;
    value     = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_hex", 64'(hex), 64'(28'hFFFFFFF));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);

    @(negedge clk);
    issue(14'd1234, {S1, S2, S3, S4}, 1'b0, "v1234", 1'b1);
    @(negedge clk);
    check("busy_after_accept", 64'(busy), 64'd1);
    wait_done("v1234");

    @(negedge clk);
    issue(14'd42, {LZ, LZ, S4, S2}, 1'b0, "v42", 1'b1);
    wait_done("v42");

    @(negedge clk);
    issue(14'd10000, {DASH, DASH, DASH, DASH}, 1'b1, "v10000", 1'b1);
    wait_done("v10000");
    @(negedge clk);
    issue(14'd9999, {S9, S9, S9, S9}, 1'b0, "v9999", 1'b1);
    wait_done("v9999");

    // Loads while busy are dropped; outputs hold the previous result mid-conversion.
    @(negedge clk);
    issue(14'd1234, {S1, S2, S3, S4}, 1'b0, "v1234_ignore", 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3 || k == 7 || k == 10) begin
        load  = 1'b1;
        value = 14'd5;
      end else begin
        load  = 1'b0;
        value = '0;
      end
      if (k == 7) begin
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_hex", 64'(hex), 64'({S9, S9, S9, S9}));
        check("hold_ovf", 64'(overflow), 64'd0);
      end
    end
    @(negedge clk);
    load  = 1'b0;
    value = '0;
    wait_done("v1234_ignore");
    issue(14'd0, {LZ, LZ, LZ, S0}, 1'b0, "v0_on_done", 1'b1);
    @(negedge clk);
    check("accept_on_done_busy", 64'(busy), 64'd1);
    wait_done("v0_on_done");

    @(negedge clk);
    issue(14'd16383, {DASH, DASH, DASH, DASH}, 1'b1, "v16383", 1'b1);
    wait_done("v16383");

    // Reset in the middle of a conversion aborts it with no done pulse.
    @(negedge clk);
    issue(14'd1234, 28'd0, 1'b0, "abort", 1'b0);
    repeat (6) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hex", 64'(hex), 64'(28'hFFFFFFF));
    check("abort_ovf", 64'(overflow), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'd0);

    @(negedge clk);
    issue(14'd7, {LZ, LZ, LZ, S7}, 1'b0, "v7_after_abort", 1'b1);
    wait_done("v7_after_abort");
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
